// File: rtl/serial_pkg.sv
// Shared definitions for the serial echo prober: FSM encodings, 8E1 frame
// constants and small helpers used by both the transmitter and the receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_CHECK     = 3'd3,
    ST_DONE      = 3'd4
  } prober_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2
  } rx_state_e;

  localparam int   FRAME_BITS  = 11;
  localparam logic PARITY_EVEN = 1'b1;

  // Frame as shifted out LSB first: start, data[0..7], parity, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {1'b1, (^b) ^ ~PARITY_EVEN, b, 1'b0};
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/serial_8e1_rx.sv
// 8E1 receiver: 2-FF synchronizer, mid-bit sampler with start-glitch rejection,
// parity and stop-bit checks. rx_valid pulses for one cycle per received frame.
module serial_8e1_rx
  import serial_pkg::*;
#(
  parameter int CLK_TICKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [1:0] rx_state
);

  localparam int             CW        = $clog2(CLK_TICKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_TICKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_TICKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nbits_q, nbits_d;
  logic [8:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [9:0]    full;

  // Bits 0..8 already shifted in, the stop bit is the live sample.
  assign full = {rx_s2_q, sh_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbits_d = nbits_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          nbits_d = '0;
          state_d = rx_s2_q ? RX_IDLE : RX_BITS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[8:1]};
          if (nbits_q == 4'd9) begin
            valid_d = 1'b1;
            data_d  = full[7:0];
            perr_d  = (^full[8:0]) ^ ~PARITY_EVEN;
            ferr_d  = ~full[9];
            state_d = RX_IDLE;
          end else begin
            nbits_d = nbits_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      nbits_q   <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      cnt_q     <= cnt_d;
      nbits_q   <= nbits_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_state   = state_q;

endmodule

// File: rtl/serial_echo_prober.sv
// Echo test master: sends NUM_BYTES 8E1 frames starting at START_BYTE and
// expects each reply to be byte+1, counting errors and timeouts.
module serial_echo_prober
  import serial_pkg::*;
#(
  parameter int         CLK_TICKS_PER_BIT = 434,
  parameter logic [7:0] START_BYTE        = 8'h00,
  parameter int         NUM_BYTES         = 256,
  parameter int         TIMEOUT_CYCLES    = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] sent_count,
  output logic [15:0] err_count,
  output logic [15:0] timeout_count,
  output logic [7:0]  last_rx,
  output logic [2:0]  dbg_state,
  output logic [1:0]  dbg_rx_state
);

  localparam int               TW         = $clog2(CLK_TICKS_PER_BIT);
  localparam logic [TW-1:0]    TICK_LAST  = TW'(CLK_TICKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST   = 4'(FRAME_BITS - 1);
  localparam int               TMW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMW-1:0]   TIMER_LAST = TMW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      NUM_TARGET = 16'(NUM_BYTES);

  prober_state_e         state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic [TMW-1:0]        timer_q, timer_d;
  logic [7:0]            cur_q, cur_d, cur_inc;
  logic [15:0]           sent_q, sent_d, err_q, err_d, to_q, to_d;
  logic [7:0]            last_rx_q, last_rx_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d;
  logic                  advance, busy_w;
  logic [1:0]            err_inc;

  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err;

  serial_8e1_rx #(
    .CLK_TICKS_PER_BIT(CLK_TICKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_state  (dbg_rx_state)
  );

  assign cur_inc = cur_q + 8'd1;
  assign busy_w  = (state_q == ST_SEND) || (state_q == ST_WAIT_ECHO) || (state_q == ST_CHECK);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    timer_d   = timer_q;
    cur_d     = cur_q;
    sent_d    = sent_q;
    err_d     = err_q;
    to_d      = to_q;
    last_rx_d = last_rx_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    advance   = 1'b0;
    err_inc   = 2'd0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SEND;
          cur_d   = START_BYTE;
          frame_d = make_frame(START_BYTE);
          tick_d  = '0;
          bit_d   = '0;
          sent_d  = '0;
          err_d   = '0;
          to_d    = '0;
        end
      end
      ST_SEND: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_WAIT_ECHO;
            timer_d = '0;
          end else begin
            bit_d   = bit_q + 4'd1;
            frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_WAIT_ECHO: begin
        if (rx_valid) begin
          last_rx_d = rx_data;
          perr_d    = parity_err;
          ferr_d    = frame_err;
          state_d   = ST_CHECK;
        end else if (timer_q == TIMER_LAST) begin
          to_d    = sat_add(to_q, 2'd1);
          advance = 1'b1;
        end else begin
          timer_d = timer_q + TMW'(1);
        end
      end
      ST_CHECK: begin
        if ((last_rx_q != cur_inc) || perr_q || ferr_q) err_inc = 2'd1;
        advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reply arriving while we are not waiting for one is discarded as an error.
    if (rx_valid && busy_w && (state_q != ST_WAIT_ECHO)) err_inc = err_inc + 2'd1;
    if (err_inc != 2'd0) err_d = sat_add(err_q, err_inc);

    if (advance) begin
      sent_d = sat_add(sent_q, 2'd1);
      cur_d  = cur_inc;
      if (sent_d == NUM_TARGET) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_SEND;
        frame_d = make_frame(cur_inc);
        tick_d  = '0;
        bit_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '1;
      tick_q    <= '0;
      bit_q     <= '0;
      timer_q   <= '0;
      cur_q     <= '0;
      sent_q    <= '0;
      err_q     <= '0;
      to_q      <= '0;
      last_rx_q <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      timer_q   <= timer_d;
      cur_q     <= cur_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
      to_q      <= to_d;
      last_rx_q <= last_rx_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign tx            = frame_q[0];
  assign busy          = busy_w;
  assign done          = (state_q == ST_DONE);
  assign pass          = (state_q == ST_DONE) && (err_q == 16'd0) && (to_q == 16'd0);
  assign sent_count    = sent_q;
  assign err_count     = err_q;
  assign timeout_count = to_q;
  assign last_rx       = last_rx_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_echo_prober.sv
// Directed bench for serial_echo_prober: four instances with different
// START_BYTE/NUM_BYTES, driven by a bench-side 8E1 echo responder.
module tb_serial_echo_prober;

  localparam int CTPB = 8;
  localparam int TOC  = 400;
  localparam logic [7:0] SB [4] = '{8'h03, 8'hFE, 8'h00, 8'h00};
  localparam int         NB [4] = '{1, 4, 4, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_r = '0;
  logic [3:0] rx_r = '1;
  logic [3:0] tx_w, busy_w, done_w, pass_w;
  logic [15:0] sent_w [4];
  logic [15:0] err_w  [4];
  logic [15:0] to_w   [4];
  logic [7:0]  last_w [4];
  logic [2:0]  st_w   [4];
  logic [1:0]  rxst_w [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_echo_prober #(
      .CLK_TICKS_PER_BIT(CTPB),
      .START_BYTE       (SB[g]),
      .NUM_BYTES        (NB[g]),
      .TIMEOUT_CYCLES   (TOC)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start_r[g]),
      .rx           (rx_r[g]),
      .tx           (tx_w[g]),
      .busy         (busy_w[g]),
      .done         (done_w[g]),
      .pass         (pass_w[g]),
      .sent_count   (sent_w[g]),
      .err_count    (err_w[g]),
      .timeout_count(to_w[g]),
      .last_rx      (last_w[g]),
      .dbg_state    (st_w[g]),
      .dbg_rx_state (rxst_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic flip, input logic stop_v);
    logic [10:0] f;
    f = {stop_v, (^d) ^ flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_r[k] = f[i];
      repeat (CTPB) @(negedge clk);
    end
    rx_r[k] = 1'b1;
  endtask

  // Waits for a start bit on tx, then samples each bit near its middle.
  task automatic capture(input int k, output logic [10:0] bits, output logic ok);
    int n;
    n = 0;
    bits = '1;
    ok = 1'b0;
    while (tx_w[k] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx_w[k] === 1'b0) begin
      ok = 1'b1;
      repeat (3) @(negedge clk);
      bits[0] = tx_w[k];
      for (int i = 1; i < 11; i++) begin
        repeat (CTPB) @(negedge clk);
        bits[i] = tx_w[k];
      end
    end
  endtask

  // extra: 0 none, 1 pulse start while busy, 2 short start glitch before the reply
  task automatic echo_byte(input int k, input logic [7:0] s, input logic [7:0] reply,
                           input logic flip, input logic stop_v, input int extra, input string tag);
    logic [10:0] bits;
    logic        ok;
    capture(k, bits, ok);
    chk({tag, "_txframe"}, {20'd0, ok, bits}, {20'd0, 1'b1, 1'b1, ^s, s, 1'b0});
    if (extra == 1) begin
      start_r[k] = 1'b1;
      @(negedge clk);
      start_r[k] = 1'b0;
      repeat (CTPB - 1) @(negedge clk);
    end else begin
      repeat (CTPB) @(negedge clk);
    end
    if (extra == 2) begin
      rx_r[k] = 1'b0;
      repeat (3) @(negedge clk);
      rx_r[k] = 1'b1;
      repeat (12) @(negedge clk);
      chk({tag, "_glitch_state"}, {29'd0, st_w[k]}, 32'd2);
    end
    send_frame(k, reply, flip, stop_v);
  endtask

  task automatic wait_done(input int k, input int budget, input string tag, output int n);
    n = 0;
    while (done_w[k] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done_w[k]}, 32'd1);
  endtask

  initial begin
    logic [87:0] samp;
    logic [10:0] fexp;
    logic [7:0]  s;
    int          n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("rst_busy_done_pass", {29'd0, busy_w[0], done_w[0], pass_w[0]}, 32'd0);
    chk("rst_counts", {sent_w[0], err_w[0] | to_w[0]}, 32'd0);
    chk("rst_last_state", {21'd0, last_w[0], st_w[0]}, 32'd0);
    rst = 1'b0;

    // Frame format: single byte 03
    pulse_start(0);
    chk("ff_busy", {31'd0, busy_w[0]}, 32'd1);
    for (int c = 0; c < 88; c++) begin
      samp[c] = tx_w[0];
      @(negedge clk);
    end
    fexp = {1'b1, 1'b0, 8'h03, 1'b0};
    for (int b = 0; b < 11; b++) begin
      chk($sformatf("ff_bit%0d", b), {24'd0, samp[b*8 +: 8]}, fexp[b] ? 32'hFF : 32'h00);
    end
    chk("ff_idle_after", {31'd0, tx_w[0]}, 32'd1);
    send_frame(0, 8'h04, 1'b0, 1'b1);
    wait_done(0, 100, "ff", n);
    chk("ff_pass_sent", {15'd0, pass_w[0], sent_w[0]}, {15'd0, 1'b1, 16'd1});
    chk("ff_last_rx", {24'd0, last_w[0]}, 32'h04);

    // Wrap-around with good echo, plus a start pulse while busy
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      s = 8'hFE + 8'(i);
      echo_byte(1, s, s + 8'd1, 1'b0, 1'b1, (i == 1) ? 1 : 0, $sformatf("wrap%0d", i));
    end
    wait_done(1, 200, "wrap", n);
    chk("wrap_pass", {31'd0, pass_w[1]}, 32'd1);
    chk("wrap_sent", {16'd0, sent_w[1]}, 32'd4);
    chk("wrap_err_to", {err_w[1], to_w[1]}, 32'd0);
    chk("wrap_last_rx", {24'd0, last_w[1]}, 32'h02);
    chk("wrap_busy", {31'd0, busy_w[1]}, 32'd0);

    // Wrong echo: reply equals the sent byte
    pulse_start(2);
    for (int i = 0; i < 4; i++) begin
      s = 8'(i);
      echo_byte(2, s, s, 1'b0, 1'b1, 0, $sformatf("wrong%0d", i));
    end
    wait_done(2, 200, "wrong", n);
    chk("wrong_err", {16'd0, err_w[2]}, 32'd4);
    chk("wrong_pass", {31'd0, pass_w[2]}, 32'd0);
    chk("wrong_last_rx", {24'd0, last_w[2]}, 32'h03);
    chk("wrong_to_sent", {to_w[2], sent_w[2]}, {16'd0, 16'd4});

    // Corrupted replies: parity flip, bad stop bit, and a start glitch
    pulse_start(2);
    chk("corr_cleared", {15'd0, done_w[2], err_w[2]}, 32'd0);
    echo_byte(2, 8'h00, 8'h01, 1'b0, 1'b1, 0, "corr0");
    echo_byte(2, 8'h01, 8'h02, 1'b1, 1'b1, 0, "corr1");
    echo_byte(2, 8'h02, 8'h03, 1'b0, 1'b0, 0, "corr2");
    echo_byte(2, 8'h03, 8'h04, 1'b0, 1'b1, 2, "corr3");
    wait_done(2, 200, "corr", n);
    chk("corr_err", {16'd0, err_w[2]}, 32'd2);
    chk("corr_to", {16'd0, to_w[2]}, 32'd0);
    chk("corr_pass_sent", {15'd0, pass_w[2], sent_w[2]}, {15'd0, 1'b0, 16'd4});
    chk("corr_last_rx", {24'd0, last_w[2]}, 32'h04);

    // No reply: every byte times out
    pulse_start(3);
    chk("nr_tx_fall", {30'd0, tx_w[3], busy_w[3]}, 32'b01);
    wait_done(3, 3000, "nr", n);
    chk("nr_cycles", n, 32'd1464);
    chk("nr_to", {16'd0, to_w[3]}, 32'd3);
    chk("nr_err", {16'd0, err_w[3]}, 32'd0);
    chk("nr_pass_sent", {15'd0, pass_w[3], sent_w[3]}, {15'd0, 1'b0, 16'd3});

    // Reset mid-frame, then a clean run from START_BYTE
    pulse_start(1);
    repeat (4) @(negedge clk);
    chk("rstmid_pre", {30'd0, tx_w[1], busy_w[1]}, 32'b01);
    rst = 1'b1;
    #1;
    chk("rstmid_tx_busy", {30'd0, tx_w[1], busy_w[1]}, 32'b10);
    chk("rstmid_state", {29'd0, st_w[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      s = 8'hFE + 8'(i);
      echo_byte(1, s, s + 8'd1, 1'b0, 1'b1, 0, $sformatf("rerun%0d", i));
    end
    wait_done(1, 200, "rerun", n);
    chk("rerun_pass_sent", {15'd0, pass_w[1], sent_w[1]}, {15'd0, 1'b1, 16'd4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
